// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/done handshake, operands and result of the bit-serial adder/subtractor.
interface serial_addsub_if #(parameter int WIDTH = 8);
    logic             start, sub, cin, busy, done, cout, overflow;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output start, sub, a, b, cin, input busy, done, sum, cout, overflow);
    modport slave  (input start, sub, a, b, cin, output busy, done, sum, cout, overflow);
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB first through one full-adder slice and a registered carry.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave io
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             s, maj, last;
    always_comb begin
        s       = a_q[0] ^ b_q[0] ^ carry_q;
        maj     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            r_d     = {s, r_q[WIDTH-1:1]};
            carry_d = maj;
            cnt_d   = cnt_q + CW'(1);
            // results become visible only on the last bit; carry_q here is the carry into the MSB
            if (last) begin
                state_d = DONE;
                sum_d   = r_d;
                cout_d  = maj;
                ovf_d   = carry_q ^ maj;
            end
        end else if (io.start) begin
            state_d = RUN;
            a_d     = io.a;
            b_d     = io.sub ? ~io.b : io.b;
            carry_d = io.sub | io.cin;
            cnt_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
    assign io.busy     = state_q == RUN;
    assign io.done     = state_q == DONE;
    assign io.sum      = sum_q;
    assign io.cout     = cout_q;
    assign io.overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed vectors at WIDTH 8/2/16 plus back-to-back, mid-run start and async reset sequences.
module tb_serial_addsub;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [63:0] a = '0, b = '0;
    int          sel = 8;
    int          n_chk = 0, n_fail = 0;
    logic        busy_w, done_w, cout_w, ovf_w;
    logic [63:0] sum_w;
    always #5 clk = ~clk;
    serial_addsub_if #(.WIDTH(8))  i8 ();
    serial_addsub_if #(.WIDTH(2))  i2 ();
    serial_addsub_if #(.WIDTH(16)) i16 ();
    serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .io(i8));
    serial_addsub #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .io(i2));
    serial_addsub #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .io(i16));
    assign i8.start  = start && sel == 8;
    assign i2.start  = start && sel == 2;
    assign i16.start = start && sel == 16;
    assign i8.a = a[7:0];   assign i8.b = b[7:0];   assign i8.sub = sub;  assign i8.cin = cin;
    assign i2.a = a[1:0];   assign i2.b = b[1:0];   assign i2.sub = sub;  assign i2.cin = cin;
    assign i16.a = a[15:0]; assign i16.b = b[15:0]; assign i16.sub = sub; assign i16.cin = cin;
    assign busy_w = sel == 8 ? i8.busy     : sel == 2 ? i2.busy     : i16.busy;
    assign done_w = sel == 8 ? i8.done     : sel == 2 ? i2.done     : i16.done;
    assign cout_w = sel == 8 ? i8.cout     : sel == 2 ? i2.cout     : i16.cout;
    assign ovf_w  = sel == 8 ? i8.overflow : sel == 2 ? i2.overflow : i16.overflow;
    assign sum_w  = sel == 8 ? 64'(i8.sum) : sel == 2 ? 64'(i2.sum) : 64'(i16.sum);

    typedef struct {
        int          w;
        logic [63:0] a, b;
        logic        cin, sub;
        logic [63:0] sum;
        logic        cout, ovf;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at the first negedge after the accepted start edge; lat counts edges start->done
    task automatic wait_done(output int lat, output int bcnt, output logic stable);
        logic [63:0] s0 = sum_w;
        lat = -1; bcnt = 0; stable = 1'b1;
        for (int j = 1; j <= 100; j++) begin
            if (done_w) begin
                lat = j - 1;
                break;
            end
            if (busy_w) bcnt++;
            if (sum_w !== s0) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int lat, bcnt;
        logic stable;
        @(negedge clk);
        sel = v.w; a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, stable);
        chk({tag, " latency"}, 64'(lat), 64'(v.w));
        chk({tag, " busy cycles"}, 64'(bcnt), 64'(v.w));
        chk({tag, " sum held during run"}, 64'(stable), 64'd1);
        chk({tag, " sum"}, sum_w, v.sum);
        chk({tag, " cout"}, 64'(cout_w), 64'(v.cout));
        chk({tag, " overflow"}, 64'(ovf_w), 64'(v.ovf));
        @(negedge clk);
        chk({tag, " done single pulse"}, 64'(done_w), 64'd0);
    endtask

    initial begin
        int lat, bcnt, dcnt, dlat;
        logic stable;
        logic [63:0] dsum;
        vecs[0]  = '{8,  64'h5A,   64'h33,   1'b0, 1'b0, 64'h8D,   1'b0, 1'b1};
        vecs[1]  = '{8,  64'hFF,   64'h01,   1'b1, 1'b0, 64'h01,   1'b1, 1'b0};
        vecs[2]  = '{8,  64'h10,   64'h20,   1'b1, 1'b1, 64'hF0,   1'b0, 1'b0};
        vecs[3]  = '{8,  64'h80,   64'h01,   1'b0, 1'b1, 64'h7F,   1'b1, 1'b1};
        vecs[4]  = '{8,  64'h7F,   64'h01,   1'b0, 1'b0, 64'h80,   1'b0, 1'b1};
        vecs[5]  = '{8,  64'h00,   64'h00,   1'b0, 1'b1, 64'h00,   1'b1, 1'b0};
        vecs[6]  = '{2,  64'h1,    64'h1,    1'b0, 1'b0, 64'h2,    1'b0, 1'b1};
        vecs[7]  = '{2,  64'h3,    64'h3,    1'b1, 1'b0, 64'h3,    1'b1, 1'b0};
        vecs[8]  = '{2,  64'h1,    64'h2,    1'b0, 1'b1, 64'h3,    1'b0, 1'b1};
        vecs[9]  = '{2,  64'h2,    64'h1,    1'b0, 1'b1, 64'h1,    1'b1, 1'b1};
        vecs[10] = '{16, 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0};
        vecs[11] = '{16, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'h0000, 1'b1, 1'b0};
        vecs[12] = '{16, 64'h8000, 64'h0001, 1'b0, 1'b1, 64'h7FFF, 1'b1, 1'b1};
        vecs[13] = '{16, 64'h7FFF, 64'h7FFF, 1'b1, 1'b0, 64'hFFFF, 1'b0, 1'b1};
        vecs[14] = '{16, 64'h1234, 64'h1234, 1'b1, 1'b1, 64'h0000, 1'b1, 1'b0};

        #3 rst_n = 1'b0;
        #3;
        chk("reset busy", 64'(busy_w), 64'd0);
        chk("reset done", 64'(done_w), 64'd0);
        chk("reset sum", sum_w, 64'd0);
        chk("reset cout", 64'(cout_w), 64'd0);
        chk("reset overflow", 64'(ovf_w), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d w%0d", i, vecs[i].w));

        // back-to-back: start held through DONE, operands swapped while busy
        @(negedge clk);
        sel = 8; a = 64'h80; b = 64'h01; sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 64'h5A; b = 64'h33; sub = 1'b0;
        wait_done(lat, bcnt, stable);
        chk("b2b first latency", 64'(lat), 64'd8);
        chk("b2b first sum", sum_w, 64'h7F);
        chk("b2b first cout", 64'(cout_w), 64'd1);
        chk("b2b first overflow", 64'(ovf_w), 64'd1);
        @(negedge clk);
        chk("b2b no idle gap busy", 64'(busy_w), 64'd1);
        start = 1'b0;
        wait_done(lat, bcnt, stable);
        chk("b2b second latency", 64'(lat), 64'd8);
        chk("b2b prior sum held", 64'(stable), 64'd1);
        chk("b2b second sum", sum_w, 64'h8D);
        chk("b2b second overflow", 64'(ovf_w), 64'd1);

        // start while busy must be ignored
        @(negedge clk);
        a = 64'h01; b = 64'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 64'hF0; b = 64'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0; dlat = -1; dsum = '1;
        for (int j = 3; j < 30; j++) begin
            if (done_w) begin
                dcnt++;
                if (dlat < 0) begin
                    dlat = j - 1;
                    dsum = sum_w;
                end
            end
            @(negedge clk);
        end
        chk("midrun done count", 64'(dcnt), 64'd1);
        chk("midrun latency", 64'(dlat), 64'd8);
        chk("midrun sum", dsum, 64'h02);

        // asynchronous reset in RUN cycle 4
        @(negedge clk);
        a = 64'h5A; b = 64'h33; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 64'(busy_w), 64'd1);
        chk("pre-reset sum", sum_w, 64'h02);
        #1 rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(busy_w), 64'd0);
        chk("async reset done", 64'(done_w), 64'd0);
        chk("async reset sum", sum_w, 64'd0);
        chk("async reset cout", 64'(cout_w), 64'd0);
        chk("async reset overflow", 64'(ovf_w), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int j = 0; j < 15; j++) begin
            if (done_w || busy_w) dcnt++;
            @(negedge clk);
        end
        chk("no activity after reset", 64'(dcnt), 64'd0);
        run_op(vecs[1], "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Processes one bit per clock, LSB first, through a single full-adder slice and a registered carry.
- Trades latency for area against the parallel ripple adder.
- Sits between a register file or operand source and a result consumer, using a start/done handshake.
- Adds subtract mode, a carry-in, and a signed-overflow flag.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled on the rising edge while not busy.
- sub  input  1  mode, captured with start: 0 = a+b+cin, 1 = a-b.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- cin  input  1  carry-in, captured with start; ignored when sub=1.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of MSB. In sub mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, cout, overflow all 0; internal shift registers, carry and bit counter all 0. Reset asserted mid-operation aborts it with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1 → RUN. On that edge:
  - load A into the A shift register.
  - load b into the B shift register if sub=0, or ~b if sub=1.
  - set carry = (sub ? 1 : cin).
  - set counter = 0.
  - latch sub.
- RUN, each edge:
  - s = A[0]^B[0]^carry.
  - carry ← majority(A[0], B[0], carry).
  - shift A and B right by 1.
  - shift the result register right with s inserted at the MSB.
  - counter += 1.
  - on the edge where counter = WIDTH-1 (the last bit): record the pre-update carry as cmsb and the post-update carry as the carry out, then go to DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - sum = full result register; cout = final carry; overflow = cmsb ^ cout.
  - next edge → IDLE, or → RUN if start=1; back-to-back operation is allowed.
- busy=1 exactly in RUN.
- start while busy is ignored; operands are not re-captured and the running operation is unaffected.
- Latency: start sampled on edge k → done high during the cycle after edge k+WIDTH. This gives WIDTH RUN cycles and a throughput of one result per WIDTH+1 cycles.
- sum, cout and overflow update only on entry to DONE and hold through IDLE. Intermediate shifting uses an internal register; outputs never show partial results.
- Arithmetic is modulo 2^WIDTH. The sub=1 path computes a + ~b + 1 (two's complement).
- Counter width is clog2(WIDTH)+1; no wrap occurs within an operation.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, sub=0 → sum=0x8D, cout=0, overflow=1; done exactly 8 cycles after the start edge, busy high for 8 cycles.
- a=0xFF, b=0x01, cin=1, sub=0 → sum=0x01, cout=1, overflow=0.
- sub=1, a=0x10, b=0x20, cin=1 (must be ignored) → sum=0xF0, cout=0, overflow=0.
- sub=1, a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1. Then start held high through DONE → second operation begins with no IDLE cycle, and the prior sum stays stable until the new done.
- Pulse start with a=0x01, b=0x01; pulse start again mid-RUN with a=0xF0, b=0x0F → first result sum=0x02 is unaffected and exactly one done pulse occurs.
- Drive rst_n low at RUN cycle 4 → busy, done, sum, cout and overflow go 0 immediately (asynchronously), no done pulse follows, and the next start completes normally. Repeat the sum/cout/overflow checks at WIDTH=2 and WIDTH=16.
